// File: rtl/fir_pkg.sv
// Widths shared by the FIR datapath and its sample feeder, plus the feeder's
// playback state encoding.
package fir_pkg;
  localparam int FIR_IN_W = 8;
  localparam int FIR_Y_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } feeder_state_e;
endpackage

// File: rtl/fir_sample_buf.sv
// Sample register file for the feeder: tail-append writes, clear, and a
// combinational read port.
module fir_sample_buf
  import fir_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IN_W  = FIR_IN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IN_W-1:0]          wr_data,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [IN_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            we;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full    = count[AW];
  assign we      = wr_en && !clr && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/fir_sample_feeder.sv
// Replays buffered samples into the FIR's in/go port with setup/strobe/settle
// timing and reports the captured y for each sample.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IN_W  = FIR_IN_W,
  parameter int Y_W   = FIR_Y_W,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IN_W-1:0]          wr_data,
  input  logic                     clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [IN_W-1:0]          fir_in,
  output logic                     fir_go,
  input  logic [Y_W-1:0]           fir_y,
  output logic                     res_valid,
  output logic [Y_W-1:0]           res_data,
  output logic [$clog2(DEPTH)-1:0] res_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  feeder_state_e   state, nxt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_sel;
  logic [AW:0]     rd_next;
  logic [GW-1:0]   gap_cnt;
  logic [IN_W-1:0] rd_data;
  logic            idle;
  logic            last_wait;

  assign idle      = (state == ST_IDLE);
  assign busy      = !idle;
  assign last_wait = (state == ST_WAIT) && (gap_cnt == '0);
  assign rd_next   = {1'b0, rd_ptr} + (AW+1)'(1);
  // SETUP is entered from IDLE (first sample) or WAIT (next sample)
  assign rd_sel    = (state == ST_WAIT) ? rd_next[AW-1:0] : '0;

  fir_sample_buf #(.DEPTH(DEPTH), .IN_W(IN_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && idle),
    .wr_data (wr_data),
    .clr     (clr && idle),
    .rd_ptr  (rd_sel),
    .rd_data (rd_data),
    .count   (count)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = (count == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP:  nxt = ST_STROBE;
      ST_STROBE: nxt = ST_WAIT;
      ST_WAIT:   if (gap_cnt == '0) nxt = (rd_next < count) ? ST_SETUP : ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
      fir_in    <= '0;
      fir_go    <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= nxt;
      fir_go    <= (nxt == ST_STROBE);
      done      <= (state == ST_DONE);
      res_valid <= last_wait;
      // fir_in only moves on SETUP entry so it is stable a full cycle before go
      if (nxt == ST_SETUP) fir_in <= rd_data;
      if (idle && start) rd_ptr <= '0;
      else if (last_wait && nxt == ST_SETUP) rd_ptr <= rd_next[AW-1:0];
      if (state == ST_STROBE) gap_cnt <= GW'(GAP - 1);
      else if (state == ST_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      if (last_wait) begin
        res_data <= fir_y;
        res_idx  <= rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench: FIR stub y=in*3 registered on go, queue-based model of
// the loaded samples, and a monitor logging go/result/done events by cycle.
module tb_fir_sample_feeder;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fir_go, res_valid;
  logic [4:0]  count;
  logic [7:0]  fir_in;
  logic [15:0] fir_y = '0;
  logic [15:0] res_data;
  logic [3:0]  res_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  model_q[$];
  int          go_cyc_q[$];
  logic [7:0]  go_in_q[$];
  logic [7:0]  pre_in_q[$];
  int          res_idx_q[$];
  logic [15:0] res_dat_q[$];
  int          res_cyc_q[$];
  int          done_cyc_q[$];
  int          go_dbl = 0;
  logic        prev_go = 1'b0;
  logic [7:0]  prev_in = '0;

  fir_sample_feeder #(.DEPTH(DEPTH), .IN_W(8), .Y_W(16), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .busy(busy), .done(done), .count(count),
    .fir_in(fir_in), .fir_go(fir_go), .fir_y(fir_y),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (fir_go) fir_y <= 16'(fir_in) * 16'd3;

  always @(posedge clk) begin
    #2;
    if (fir_go) begin
      go_cyc_q.push_back(cyc);
      go_in_q.push_back(fir_in);
      pre_in_q.push_back(prev_in);
      if (prev_go) go_dbl <= go_dbl + 1;
    end
    if (res_valid) begin
      res_idx_q.push_back(int'(res_idx));
      res_dat_q.push_back(res_data);
      res_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    prev_go <= fir_go;
    prev_in <= fir_in;
  end

  task automatic clear_mon();
    go_cyc_q.delete(); go_in_q.delete(); pre_in_q.delete();
    res_idx_q.delete(); res_dat_q.delete(); res_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1 wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic clear_buf();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_q.delete();
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk); s = cyc; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int s; bit ok; int g0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, fir_go, res_valid} !== 4'b0) begin failures++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, fir_go, res_valid}); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (fir_in !== 8'd0) begin failures++; $display("FAIL reset_fir_in: got %0d expected 0", fir_in); end
    checks++; if (res_data !== 16'd0 || res_idx !== 4'd0) begin failures++;
      $display("FAIL reset_res: got data=%0d idx=%0d expected 0/0", res_data, res_idx); end
    rst = 1'b0;
    model_q.delete();
    clear_mon();
    g0 = go_dbl;
    pulse_start(s);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_done: got no done expected pulse"); end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 2) begin failures++;
      $display("FAIL empty_done_cycle: got n=%0d cyc=%0d expected 1 at %0d",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, s + 2); end
    checks++; if (go_cyc_q.size() != 0 || res_cyc_q.size() != 0) begin failures++;
      $display("FAIL empty_no_go: got go=%0d res=%0d expected 0/0", go_cyc_q.size(), res_cyc_q.size()); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_width: got %b expected 0", done); end
  endtask

  task automatic test_basic();
    int s; bit ok; int g0;
    clear_buf();
    load(8'd1); load(8'd2);
    clear_mon();
    g0 = go_dbl;
    pulse_start(s);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done: got timeout expected done"); end
    checks++; if (go_cyc_q.size() != 2) begin failures++;
      $display("FAIL basic_go_count: got %0d expected 2", go_cyc_q.size()); end
    else begin
      checks++; if (go_cyc_q[0] != s + 2 || go_cyc_q[1] != s + 2 + (2 + GAP)) begin failures++;
        $display("FAIL basic_go_cycle: got %0d,%0d expected %0d,%0d", go_cyc_q[0], go_cyc_q[1], s + 2, s + 4 + GAP); end
      checks++; if (go_in_q[0] !== 8'd1 || pre_in_q[0] !== 8'd1) begin failures++;
        $display("FAIL basic_setup: got in=%0d pre=%0d expected 1/1", go_in_q[0], pre_in_q[0]); end
    end
    checks++; if (go_dbl != g0) begin failures++; $display("FAIL basic_go_single: got %0d doubles expected 0", go_dbl - g0); end
    checks++; if (res_cyc_q.size() != 2) begin failures++;
      $display("FAIL basic_res_count: got %0d expected 2", res_cyc_q.size()); end
    else begin
      checks++; if (res_idx_q[0] != 0 || res_dat_q[0] !== 16'd3 || res_idx_q[1] != 1 || res_dat_q[1] !== 16'd6) begin
        failures++; $display("FAIL basic_res: got %0d:%0d %0d:%0d expected 0:3 1:6",
                              res_idx_q[0], res_dat_q[0], res_idx_q[1], res_dat_q[1]); end
      checks++; if (res_cyc_q[0] != s + 3 + GAP) begin failures++;
        $display("FAIL basic_res_latency: got %0d expected %0d", res_cyc_q[0], s + 3 + GAP); end
      checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != res_cyc_q[1] + 1) begin failures++;
        $display("FAIL basic_done_cycle: got n=%0d expected done at %0d", done_cyc_q.size(), res_cyc_q[1] + 1); end
    end
  endtask

  task automatic test_full();
    int s; bit ok; int bad = 0;
    clear_buf();
    for (int i = 0; i < DEPTH + 1; i++) load(8'($urandom));
    @(negedge clk);
    checks++; if (count !== 5'(model_q.size())) begin failures++;
      $display("FAIL full_count: got %0d expected %0d", count, model_q.size()); end
    clear_mon();
    pulse_start(s);
    wait_done(ok);
    checks++; if (!ok || res_cyc_q.size() != model_q.size()) begin failures++;
      $display("FAIL full_res_count: got %0d expected %0d", res_cyc_q.size(), model_q.size()); end
    else begin
      for (int i = 0; i < model_q.size(); i++)
        if (res_idx_q[i] != i || res_dat_q[i] !== 16'(model_q[i]) * 16'd3 || go_in_q[i] !== model_q[i]) bad++;
      checks++; if (bad != 0) begin failures++;
        $display("FAIL full_res_data: got %0d wrong entries expected 0", bad); end
    end
  endtask

  task automatic test_busy_ignore();
    int s; int n; bit left = 1'b0; int bad = 0;
    clear_buf();
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) load(8'($urandom));
    clear_mon();
    pulse_start(s);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin left = 1'b1; break; end
      wr_en = 1'($urandom); clr = 1'($urandom); start = 1'($urandom); wr_data = 8'($urandom);
      @(posedge clk); #1 wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    end
    checks++; if (!left || done_cyc_q.size() != 1) begin failures++;
      $display("FAIL busy_done: got left=%0d done=%0d expected 1/1", left, done_cyc_q.size()); end
    checks++; if (count !== 5'(n)) begin failures++; $display("FAIL busy_count: got %0d expected %0d", count, n); end
    checks++; if (res_cyc_q.size() != n) begin failures++;
      $display("FAIL busy_res_count: got %0d expected %0d", res_cyc_q.size(), n); end
    else begin
      for (int i = 0; i < n; i++)
        if (res_idx_q[i] != i || res_dat_q[i] !== 16'(model_q[i]) * 16'd3) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL busy_res_data: got %0d wrong expected 0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_buf();
    for (int i = 0; i < 3; i++) load(8'($urandom));
    clear_mon();
    pulse_start(s);
    while (cyc < s + 2 + (2 + GAP) + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({fir_go, busy, res_valid} !== 3'b0 || count !== 5'd0) begin failures++;
      $display("FAIL midrst_state: got go/busy/rv=%b count=%0d expected 000/0", {fir_go, busy, res_valid}, count); end
    rst = 1'b0;
    model_q.delete();
    repeat (12) @(negedge clk);
    checks++; if (res_cyc_q.size() != 1 || go_cyc_q.size() != 2) begin failures++;
      $display("FAIL midrst_quiet: got res=%0d go=%0d expected 1/2", res_cyc_q.size(), go_cyc_q.size()); end
  endtask

  task automatic test_replay();
    int s1, s2; bit ok1, ok2; int bad = 0;
    int go1[$]; logic [7:0] in1[$]; logic [15:0] d1[$]; int r1[$];
    clear_buf();
    for (int i = 0; i < 4; i++) load(8'($urandom));
    clear_mon();
    pulse_start(s1);
    wait_done(ok1);
    foreach (go_cyc_q[i]) go1.push_back(go_cyc_q[i] - s1);
    in1 = go_in_q; d1 = res_dat_q;
    foreach (res_cyc_q[i]) r1.push_back(res_cyc_q[i] - s1);
    clear_mon();
    pulse_start(s2);
    wait_done(ok2);
    checks++; if (!ok1 || !ok2 || go_cyc_q.size() != 4 || go1.size() != 4 || res_cyc_q.size() != 4 || r1.size() != 4) begin
      failures++; $display("FAIL replay_count: got go=%0d/%0d res=%0d/%0d expected 4", go1.size(), go_cyc_q.size(), r1.size(), res_cyc_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (go_cyc_q[i] - s2 != go1[i] || go_in_q[i] !== in1[i] || res_cyc_q[i] - s2 != r1[i]) bad++;
        if (res_dat_q[i] !== d1[i] || res_dat_q[i] !== 16'(model_q[i]) * 16'd3) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL replay_match: got %0d differences expected 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_busy_ignore();
    test_reset_mid();
    test_replay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
